// File: rtl/fir_mem_seq.sv
// fir_mem_seq: sequences one FIR pass over a block of samples.
// Samples are read from an input memory, pass through an external FIR with
// a fixed latency, and the results are written to an output memory.
// Optional feature: define FIR_MEM_SEQ_CYC_CNT_EN to add the 16-bit
// run_cycles output, which counts the busy cycles of the latest run.
//
// Handshake: start is a level request that is accepted only while idle and
// not in the cycle that shows the done pulse. abort cancels a run at the next
// edge from any busy state. rst overrides both.
//
// Timing model: the FSM register holds the state that decides what the
// memories see in the *next* cycle. All outputs are registered from the same
// next-state logic, so dbg_state leads the memory strobes by one cycle.
module fir_mem_seq #(
  parameter int N_SAMPLES = 256,
  parameter int FIR_LAT   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        fir_clr,
  output logic        in_nce,
  output logic [5:0]  in_ra,
  output logic [1:0]  in_ca,
  output logic        out_nce,
  output logic        out_nwrt,
  output logic [5:0]  out_ra,
  output logic [1:0]  out_ca,
  output logic [7:0]  out_index,
`ifdef FIR_MEM_SEQ_CYC_CNT_EN
  output logic [15:0] run_cycles,
`endif
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] LAST   = 8'(N_SAMPLES - 1);
  localparam logic [5:0] LAT    = 6'(FIR_LAT);
  localparam logic [5:0] LAT_M1 = 6'(FIR_LAT - 1);

  state_t     state, state_n;
  logic [7:0] rd_idx, rd_n;
  logic [7:0] wr_idx, wr_n;
  logic [5:0] lat_cnt, lat_n;
  logic       rd_en, wr_en, clr_en, done_en, busy_n;

  assign dbg_state = state;

  // Next-state, counter and strobe decisions for the coming cycle.
  always_comb begin
    state_n = state;
    rd_n    = rd_idx;
    wr_n    = wr_idx;
    lat_n   = lat_cnt;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    clr_en  = 1'b0;
    done_en = 1'b0;
    case (state)
      S_IDLE: begin
        // done still high means this is the visible DONE cycle: ignore start.
        if (start && !done) begin
          state_n = S_FILL;
          rd_n    = 8'd0;
          wr_n    = 8'd0;
          lat_n   = 6'd0;
        end
      end
      S_FILL: begin
        rd_en  = 1'b1;
        clr_en = (rd_idx == 8'd0);
        lat_n  = lat_cnt + 6'd1;
        // Running out of samples wins over reaching the FIR latency.
        if (rd_idx == LAST) begin
          state_n = S_DRAIN;
        end else begin
          rd_n = rd_idx + 8'd1;
          if (lat_cnt == LAT_M1) state_n = S_RUN;
        end
      end
      S_RUN: begin
        rd_en = 1'b1;
        wr_en = 1'b1;
        // The write index trails the read index, so it cannot be last here.
        wr_n  = wr_idx + 8'd1;
        if (rd_idx == LAST) state_n = S_DRAIN;
        else                rd_n    = rd_idx + 8'd1;
      end
      S_DRAIN: begin
        // A short run reaches DRAIN before the first result exists; keep
        // counting the latency until writes may begin.
        if (lat_cnt != LAT) begin
          lat_n = lat_cnt + 6'd1;
        end else begin
          wr_en = 1'b1;
          if (wr_idx == LAST) state_n = S_DONE;
          else                wr_n    = wr_idx + 8'd1;
        end
      end
      S_DONE: begin
        done_en = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // abort beats every transition, including the final write and done.
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      clr_en  = 1'b0;
      done_en = 1'b0;
    end
    busy_n = (state_n != S_IDLE) || done_en;
  end

  // State, counters and registered memory-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_idx    <= 8'd0;
      wr_idx    <= 8'd0;
      lat_cnt   <= 6'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fir_clr   <= 1'b0;
      in_nce    <= 1'b1;
      in_ra     <= 6'd0;
      in_ca     <= 2'd0;
      out_nce   <= 1'b1;
      out_nwrt  <= 1'b1;
      out_ra    <= 6'd0;
      out_ca    <= 2'd0;
      out_index <= 8'd0;
    end else begin
      state    <= state_n;
      rd_idx   <= rd_n;
      wr_idx   <= wr_n;
      lat_cnt  <= lat_n;
      busy     <= busy_n;
      done     <= done_en;
      fir_clr  <= clr_en;
      in_nce   <= !rd_en;
      out_nce  <= !wr_en;
      out_nwrt <= !wr_en;
      if (rd_en) begin
        in_ra <= rd_idx[7:2];
        in_ca <= rd_idx[1:0];
      end
      if (wr_en) begin
        out_ra    <= wr_idx[7:2];
        out_ca    <= wr_idx[1:0];
        out_index <= wr_idx;
      end
    end
  end

`ifdef FIR_MEM_SEQ_CYC_CNT_EN
  // Busy-cycle counter: cleared on start acceptance, frozen while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cycles <= 16'd0;
    end else if (state == S_IDLE && state_n == S_FILL) begin
      run_cycles <= 16'd0;
    end else if (busy_n) begin
      run_cycles <= run_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_mem_seq.sv
// tb_fir_mem_seq: randomized bench for fir_mem_seq.
// Two instances: the default geometry and a short run (4 samples, latency 7)
// whose reads finish before the FIR latency elapses.
module tb_fir_mem_seq;

  localparam int N0 = 256;
  localparam int L0 = 7;
  localparam int N1 = 4;
  localparam int L1 = 7;
  localparam int NEVER = 1 << 19;

  // Event kinds, in the order the monitor reports them within one cycle.
  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_CLR  = 2;
  localparam int EV_RD   = 3;
  localparam int EV_WR   = 4;
  localparam int EV_DONE = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst, start0, abort0, start1, abort1;

  logic       busy0, done0, clr0, in_nce0, out_nce0, out_nwrt0;
  logic [5:0] in_ra0, out_ra0;
  logic [1:0] in_ca0, out_ca0;
  logic [7:0] out_index0;
  logic [2:0] dbg0;
  logic       busy1, done1, clr1, in_nce1, out_nce1, out_nwrt1;
  logic [5:0] in_ra1, out_ra1;
  logic [1:0] in_ca1, out_ca1;
  logic [7:0] out_index1;
  logic [2:0] dbg1;
`ifdef FIR_MEM_SEQ_CYC_CNT_EN
  logic [15:0] rc0, rc1;
`endif

  fir_mem_seq #(.N_SAMPLES(N0), .FIR_LAT(L0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .busy(busy0), .done(done0), .fir_clr(clr0),
    .in_nce(in_nce0), .in_ra(in_ra0), .in_ca(in_ca0),
    .out_nce(out_nce0), .out_nwrt(out_nwrt0), .out_ra(out_ra0), .out_ca(out_ca0),
    .out_index(out_index0),
`ifdef FIR_MEM_SEQ_CYC_CNT_EN
    .run_cycles(rc0),
`endif
    .dbg_state(dbg0)
  );

  fir_mem_seq #(.N_SAMPLES(N1), .FIR_LAT(L1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .busy(busy1), .done(done1), .fir_clr(clr1),
    .in_nce(in_nce1), .in_ra(in_ra1), .in_ca(in_ca1),
    .out_nce(out_nce1), .out_nwrt(out_nwrt1), .out_ra(out_ra1), .out_ca(out_ca1),
    .out_index(out_index1),
`ifdef FIR_MEM_SEQ_CYC_CNT_EN
    .run_cycles(rc1),
`endif
    .dbg_state(dbg1)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  logic bprev0, bprev1;

  function automatic logic [31:0] ev(input int d, input int t, input int idx, input int c);
    return {d[0], t[2:0], idx[7:0], c[19:0]};
  endfunction

  task automatic check_ev(input logic [31:0] got);
    logic [31:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL event: got dut%0d kind %0d idx %0d cyc %0d, required no event",
               got[31], got[30:28], got[27:20], got[19:0]);
    end else begin
      e = exp_q.pop_front();
      if (e !== got) begin
        fails++;
        $display("FAIL event: got dut%0d kind %0d idx %0d cyc %0d, required dut%0d kind %0d idx %0d cyc %0d",
                 got[31], got[30:28], got[27:20], got[19:0], e[31], e[30:28], e[27:20], e[19:0]);
      end
    end
  endtask

  // Turns one DUT's pins into events for the current cycle.
  task automatic mon_dut(input int d, input logic b, input logic bp, input logic dn,
                         input logic clr, input logic inn, input logic [5:0] ira,
                         input logic [1:0] ica, input logic onc, input logic onw,
                         input logic [5:0] ora, input logic [1:0] oca, input logic [7:0] oix);
    if (b && !bp) check_ev(ev(d, EV_RISE, 0, cyc));
    if (!b && bp) check_ev(ev(d, EV_FALL, 0, cyc));
    if (clr) check_ev(ev(d, EV_CLR, 0, cyc));
    if (!inn) check_ev(ev(d, EV_RD, {24'd0, ira, ica}, cyc));
    if (!onc || !onw) begin
      check_ev(ev(d, EV_WR, {24'd0, ora, oca}, cyc));
      tests++;
      if (onc !== onw || oix !== {ora, oca}) begin
        fails++;
        $display("FAIL wr_pins dut%0d cyc %0d: got nce %b nwrt %b index %0d, required nce=nwrt=0 index %0d",
                 d, cyc, onc, onw, oix, {ora, oca});
      end
    end
    if (dn) check_ev(ev(d, EV_DONE, 0, cyc));
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_dut(0, busy0, bprev0, done0, clr0, in_nce0, in_ra0, in_ca0,
              out_nce0, out_nwrt0, out_ra0, out_ca0, out_index0);
      mon_dut(1, busy1, bprev1, done1, clr1, in_nce1, in_ra1, in_ca1,
              out_nce1, out_nwrt1, out_ra1, out_ca1, out_index1);
      bprev0 = busy0;
      bprev1 = busy1;
    end
  end

  // ---------------- reference model ----------------
  // A run accepted at cycle t0 reads sample k in t0+1+k, writes it in
  // t0+1+k+l, pulses done in t0+n+l+1 and drops busy in t0+n+l+2.
  // An abort or reset during cycle 'stop' removes every event after it.
  task automatic push_run(input int d, input int n, input int l, input int t0, input int stop);
    int fall;
    fall = (stop + 1 < n + l + 2) ? stop + 1 : n + l + 2;
    for (int k = 0; k <= fall; k++) begin
      if (k == 0) exp_q.push_back(ev(d, EV_RISE, 0, t0));
      if (k == fall) exp_q.push_back(ev(d, EV_FALL, 0, t0 + k));
      if (k <= stop) begin
        if (k == 1) exp_q.push_back(ev(d, EV_CLR, 0, t0 + k));
        if (k >= 1 && k <= n) exp_q.push_back(ev(d, EV_RD, k - 1, t0 + k));
        if (k >= 1 + l && k <= n + l) exp_q.push_back(ev(d, EV_WR, k - 1 - l, t0 + k));
        if (k == n + l + 1) exp_q.push_back(ev(d, EV_DONE, 0, t0 + k));
      end
    end
  endtask

  function automatic logic [29:0] pin_vec(input int d);
    if (d == 0)
      return {busy0, done0, clr0, in_nce0, out_nce0, out_nwrt0,
              in_ra0, in_ca0, out_ra0, out_ca0, out_index0};
    return {busy1, done1, clr1, in_nce1, out_nce1, out_nwrt1,
            in_ra1, in_ca1, out_ra1, out_ca1, out_index1};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input int d, input logic s, input logic a);
    if (d == 0) begin start0 = s; abort0 = a; end
    else        begin start1 = s; abort1 = a; end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_reset_pins(input int d, input string name);
    logic [29:0] want;
    want = {6'b000111, 24'd0};
    tests++;
    if (pin_vec(d) !== want) begin
      fails++;
      $display("FAIL %s dut%0d: got %b, required %b", name, d, pin_vec(d), want);
    end
  endtask

  // kind: 0 = full run, 1 = abort during cycle 'at', 2 = rst during cycle 'at'.
  task automatic run(input int d, input int n, input int l, input int kind,
                     input int at, input bit done_start);
    int t0;
    @(negedge clk);
    set_in(d, 1'b1, 1'b0);
    @(posedge clk);
    #1 t0 = cyc;
    push_run(d, n, l, t0, (kind == 0) ? NEVER : at);
    @(negedge clk);
    set_in(d, 1'b0, 1'b0);
    // a start pulse in the middle of the run must be ignored
    if ($urandom_range(0, 1) == 1 && kind == 0) begin
      wait_cyc(t0 + $urandom_range(1, n + l));
      set_in(d, 1'b1, 1'b0);
      @(negedge clk);
      set_in(d, 1'b0, 1'b0);
    end
    if (kind != 0) begin
      wait_cyc(t0 + at);
      if (kind == 1) set_in(d, 1'b0, 1'b1);
      else           rst = 1'b1;
      @(negedge clk);
      set_in(d, 1'b0, 1'b0);
      rst = 1'b0;
      if (kind == 2) check_reset_pins(d, "mid_run_reset");
    end else if (done_start) begin
      // start presented exactly in the visible done cycle
      wait_cyc(t0 + n + l + 1);
      set_in(d, 1'b1, 1'b0);
      @(negedge clk);
      set_in(d, 1'b0, 1'b0);
    end
    wait_cyc(t0 + n + l + 4);
`ifdef FIR_MEM_SEQ_CYC_CNT_EN
    begin
      logic [15:0] got, want;
      got  = (d == 0) ? rc0 : rc1;
      want = (kind == 0) ? 16'(n + l + 1) : (kind == 1) ? 16'(at) : 16'd0;
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL run_cycles dut%0d: got %0d, required %0d", d, got, want);
      end
    end
`endif
    repeat ($urandom_range(0, 4)) @(negedge clk);
  endtask

  // start held high: the second run starts in the first idle cycle after done.
  task automatic run_held(input int d, input int n, input int l);
    int t0, t1;
    @(negedge clk);
    set_in(d, 1'b1, 1'b0);
    @(posedge clk);
    #1 t0 = cyc;
    t1 = t0 + n + l + 3;
    push_run(d, n, l, t0, NEVER);
    push_run(d, n, l, t1, NEVER);
    wait_cyc(t1 + 2);
    set_in(d, 1'b0, 1'b0);
    wait_cyc(t1 + n + l + 4);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_pins(0, "reset_state");
    check_reset_pins(1, "reset_state");
    tests++;
    if (dbg0 !== 3'd0 || dbg1 !== 3'd0) begin
      fails++;
      $display("FAIL reset_dbg_state: got %0d/%0d, required 0/0", dbg0, dbg1);
    end
    bprev0 = busy0;
    bprev1 = busy1;
    mon_en = 1'b1;

    // default geometry: full run, abort at 100, reset at 200 then full run
    run(0, N0, L0, 0, 0, 1'b0);
    run(0, N0, L0, 1, 100, 1'b0);
    run(0, N0, L0, 2, 200, 1'b0);
    run(0, N0, L0, 0, 0, 1'b0);
    run_held(0, N0, L0);
    // abort in the last write cycle must suppress done
    run(0, N0, L0, 1, N0 + L0, 1'b0);
    for (int i = 0; i < 3; i++)
      run(0, N0, L0, $urandom_range(0, 2), $urandom_range(0, N0 + L0), 1'b0);

    // short run: FILL goes straight to DRAIN
    run(1, N1, L1, 0, 0, 1'b1);
    run_held(1, N1, L1);
    run(1, N1, L1, 1, 0, 1'b0);
    for (int i = 0; i < 10; i++)
      run(1, N1, L1, $urandom_range(0, 2), $urandom_range(0, N1 + L1),
          1'($urandom_range(0, 1)));

    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_events: got %0d events still expected, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
